// File: rtl/y_mon_pkg.sv
// Shared constants, state encoding and the 160-bit fold used by the y response monitor.
package y_mon_pkg;

    localparam int          WIDTH_DEFAULT = 136;
    localparam logic [31:0] MISR_POLY     = 32'h04C11DB7;
    localparam logic [31:0] MISR_SEED     = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } y_mon_state_t;

    // XOR of the five 32-bit chunks of a zero-extended response.
    function automatic logic [31:0] fold160(input logic [159:0] v);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < 5; i++) begin
            f = f ^ v[i*32 +: 32];
        end
        return f;
    endfunction

endpackage

// File: rtl/y_compare_monitor_if.sv
// Bundle of run control, response inputs and result outputs of the y compare monitor.
interface y_compare_monitor_if
    import y_mon_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = 16,
    parameter int IDX_W = 8
);
    logic             start;
    logic [CNT_W-1:0] num_vectors;
    logic             y_valid;
    logic [WIDTH-1:0] y_ref;
    logic [WIDTH-1:0] y_dut;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] mismatch_count;
    logic [CNT_W-1:0] first_fail_idx;
    logic [IDX_W-1:0] first_diff_bit;
    logic [31:0]      sig_ref;
    logic [31:0]      sig_dut;

    modport master (
        output start, num_vectors, y_valid, y_ref, y_dut,
        input  busy, done, pass, mismatch_count, first_fail_idx, first_diff_bit,
               sig_ref, sig_dut
    );

    modport slave (
        input  start, num_vectors, y_valid, y_ref, y_dut,
        output busy, done, pass, mismatch_count, first_fail_idx, first_diff_bit,
               sig_ref, sig_dut
    );
endinterface

// File: rtl/y_misr.sv
// 32-bit MISR compacting one response stream; load has priority over en.
module y_misr
    import y_mon_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [31:0]      sig
);
    logic [31:0]  sig_q;
    logic [31:0]  sig_d;
    logic [159:0] din_ext;

    always_comb begin
        din_ext             = '0;
        din_ext[WIDTH-1:0]  = din;
        sig_d               = sig_q;
        if (load) begin
            sig_d = MISR_SEED;
        end else if (en) begin
            sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ fold160(din_ext);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
endmodule

// File: rtl/y_compare_monitor.sv
// Compares reference and netlist y responses vector by vector, tracks the first
// failure and compacts both streams into MISR signatures.
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   RUN     | accepting vectors on y_valid until num_vectors have been seen
//   DONE    | results frozen, waiting for the next start
module y_compare_monitor
    import y_mon_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = 16,
    parameter int IDX_W = 8
) (
    input logic                clk,
    input logic                rst,
    y_compare_monitor_if.slave bus
);
    y_mon_state_t     state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
    logic [CNT_W-1:0] mism_q, mism_d;
    logic [CNT_W-1:0] ffi_q, ffi_d;
    logic [IDX_W-1:0] fdb_q, fdb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             start_ok;
    logic             accept;
    logic             last_vec;
    logic [WIDTH-1:0] diff;
    logic [IDX_W-1:0] low_bit;
    logic [31:0]      sig_ref_w, sig_dut_w;

    assign start_ok = bus.start && (state_q != ST_RUN);
    assign accept   = (state_q == ST_RUN) && bus.y_valid;
    assign last_vec = accept && (vec_idx_q == num_q - CNT_W'(1));
    assign diff     = bus.y_ref ^ bus.y_dut;

    // Descending scan so the lowest set bit wins.
    always_comb begin
        low_bit = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (diff[i]) low_bit = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) state_d = (bus.num_vectors == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (last_vec) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        num_d     = num_q;
        vec_idx_d = vec_idx_q;
        mism_d    = mism_q;
        ffi_d     = ffi_q;
        fdb_d     = fdb_q;
        if (start_ok) begin
            num_d     = bus.num_vectors;
            vec_idx_d = '0;
            mism_d    = '0;
            ffi_d     = '0;
            fdb_d     = '0;
        end else if (accept) begin
            vec_idx_d = vec_idx_q + CNT_W'(1);
            if (diff != '0) begin
                mism_d = (&mism_q) ? mism_q : mism_q + CNT_W'(1);
                // A zero count means no earlier mismatch; saturation never wraps back to zero.
                if (mism_q == '0) begin
                    ffi_d = vec_idx_q;
                    fdb_d = low_bit;
                end
            end
        end
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (mism_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q     <= '0;
            vec_idx_q <= '0;
            mism_q    <= '0;
            ffi_q     <= '0;
            fdb_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            num_q     <= num_d;
            vec_idx_q <= vec_idx_d;
            mism_q    <= mism_d;
            ffi_q     <= ffi_d;
            fdb_q     <= fdb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    y_misr #(.WIDTH(WIDTH)) u_misr_ref (
        .clk  (clk),
        .rst  (rst),
        .load (start_ok),
        .en   (accept),
        .din  (bus.y_ref),
        .sig  (sig_ref_w)
    );

    y_misr #(.WIDTH(WIDTH)) u_misr_dut (
        .clk  (clk),
        .rst  (rst),
        .load (start_ok),
        .en   (accept),
        .din  (bus.y_dut),
        .sig  (sig_dut_w)
    );

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.mismatch_count = mism_q;
    assign bus.first_fail_idx = ffi_q;
    assign bus.first_diff_bit = fdb_q;
    assign bus.sig_ref        = sig_ref_w;
    assign bus.sig_dut        = sig_dut_w;
endmodule

// File: doc/y_compare_monitor.md
# y_compare_monitor

Downstream checking stage for the equivalence-simulation flow. It consumes the 136-bit `y` response of the reference RTL `top` and of the synthesized netlist `top` on the same clock, and compares them vector by vector. It also compacts each stream into a 32-bit MISR signature. At the end of a run it reports pass/fail, the mismatch count and the first failing vector and bit, so the bench no longer diffs `$strobe` logs.

## Interface
Parameters:
- `WIDTH`, 136: response width (`y` is [WIDTH-1:0]).
- `CNT_W`, 16: width of the vector counters.
- `IDX_W`, 8: width of the bit-index output; must satisfy 2^IDX_W ≥ WIDTH.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; arms a run. Honoured only in IDLE or DONE.
- `num_vectors`  in  CNT_W  vectors expected in the run; sampled on `start`.
- `y_valid`  in  1  both response inputs carry a vector this cycle.
- `y_ref`  in  WIDTH  response from the reference RTL.
- `y_dut`  in  WIDTH  response from the synthesized netlist.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE; held until the next `start` or `rst`.
- `pass`  out  1  valid when `done`; 1 iff `mismatch_count`==0.
- `mismatch_count`  out  CNT_W  number of accepted vectors with `y_ref`≠`y_dut`; saturates at all-ones.
- `first_fail_idx`  out  CNT_W  0-based index of the first mismatching vector.
- `first_diff_bit`  out  IDX_W  lowest differing bit position in that vector.
- `sig_ref`  out  32  MISR signature of the reference stream.
- `sig_dut`  out  32  MISR signature of the netlist stream.

## Operation
- FSM with states IDLE, RUN and DONE. The state is encoded as a 2-bit enum.
- IDLE → RUN on `start`:
  - `num_vectors` is latched.
  - `vec_idx`, `mismatch_count`, `first_fail_idx` and `first_diff_bit` are cleared.
  - Both signatures load SEED = 32'hFFFFFFFF.
- If `num_vectors`==0, `start` goes directly to DONE and `pass`=1.
- Each RUN cycle with `y_valid`=1 accepts one vector:
  - Compute diff = `y_ref` ^ `y_dut`.
  - If diff≠0, `mismatch_count` increments (saturating).
  - On the first mismatch only, `first_fail_idx` ← `vec_idx` and `first_diff_bit` ← index of the lowest set bit of diff.
  - Each MISR updates as sig ← {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold(y), with POLY = 32'h04C11DB7.
  - fold(y) zero-extends y to 160 bits, then XORs the five 32-bit chunks.
  - `vec_idx` increments.
- RUN → DONE on the accepted vector where `vec_idx`==`num_vectors`-1.
- `y_valid`=0 in RUN stalls the run: no state changes.
- DONE → RUN on `start`, with the same clearing as from IDLE. Outputs stay frozen in DONE otherwise.
- `start` while in RUN is ignored. `y_valid` outside RUN is ignored.
- `pass` = (`mismatch_count`==0) is registered, so it is not an equal-signature check. Signatures are diagnostic only.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `pass`=0, `mismatch_count`=0, `first_fail_idx`=0, `first_diff_bit`=0, `sig_ref`=0, `sig_dut`=0, FSM=IDLE.
- `busy` rises the cycle after `start`. The first vector can be accepted in that same cycle.
- The effect of vector k on the counters and signatures is visible one cycle after its acceptance edge.
- `done`/`pass` rise one cycle after the final vector is accepted, and `busy` falls in the same cycle.
- With `num_vectors`==0, `done`=1 the cycle after `start`.
- Asserting `rst` mid-run returns to IDLE immediately, without waiting for a clock. All outputs go to their reset values, and no partial result is retained.

## Structure
- Package `y_mon_pkg` holds:
  - `WIDTH_DEFAULT`, `MISR_POLY`, `MISR_SEED`;
  - the state enum `y_mon_state_t`;
  - the function `fold160`.
- Sub-module `y_misr`:
  - ports `clk`, `rst`, `load`, `en`, `din[WIDTH-1:0]`, `sig[31:0]`;
  - instantiated twice, once per stream.
- First-diff-bit priority encoder: a combinational loop inside `y_compare_monitor`.

## Test plan
- Identical streams, `num_vectors`=3, vectors 0, all-ones, 136'h1 → `done` 1 cycle after the 3rd vector, `pass`=1, `mismatch_count`=0, `sig_ref`==`sig_dut`.
- `num_vectors`=4, vector 2 differs only in bit 135 → `mismatch_count`=1, `first_fail_idx`=2, `first_diff_bit`=8'h87, `pass`=0.
- One all-zero vector on both inputs → `sig_ref`=`sig_dut`=32'hFB3EE249, `pass`=1.
- `num_vectors`=5 with `y_valid` toggling 1,0,1,0 → DONE only after the 5th accepted vector; a `start` pulse mid-run has no effect.
- `rst` asserted after 2 of 4 vectors → outputs 0 asynchronously, FSM IDLE; a new `start` with `num_vectors`=0 → `done`=1, `pass`=1 next cycle, signatures FFFFFFFF.
- Vectors 1 and 3 both mismatch with differing bits {5,9} and {0} → `mismatch_count`=2, `first_fail_idx`=1, `first_diff_bit`=5.
